// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async slow signal in in_clk cycles.
// Define PERIOD_METER_DUTY_EN to implement high_time; otherwise it is tied to 0.
module clk_period_meter #(
  parameter int CNT_WIDTH = 33,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT = 33'd200000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 in_clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 meas_ready,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 locked,
  output logic                 timeout,
  output logic                 overrun
);
  typedef enum logic {WAIT_EDGE, MEASURE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist, sync, rise, done, load, expire;
  logic [CNT_WIDTH-1:0] period_cnt;
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign done = state == MEASURE && rise;
  assign expire = state == MEASURE && !rise && period_cnt == TIMEOUT;
  // a completion is accepted when the output slot is empty or being drained this cycle
  assign load = done && (!meas_valid || meas_ready);
  always_ff @(posedge in_clk)
    if (rst) begin
      state <= WAIT_EDGE;
      sync_q <= '0;
      hist <= 1'b0;
      period_cnt <= '0;
      period <= '0;
      meas_valid <= 1'b0;
      locked <= 1'b0;
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist <= sync;
      if (rise) begin
        state <= MEASURE;
        period_cnt <= CNT_WIDTH'(1);
      end else if (expire) begin
        state <= WAIT_EDGE;
        period_cnt <= '0;
        timeout <= 1'b1;
        locked <= 1'b0;
      end else if (state == MEASURE) period_cnt <= period_cnt + CNT_WIDTH'(1);
      if (load) begin
        period <= period_cnt;
        meas_valid <= 1'b1;
        locked <= 1'b1;
        timeout <= 1'b0;
      end else begin
        if (done) overrun <= 1'b1;
        if (meas_valid && meas_ready) meas_valid <= 1'b0;
      end
    end
`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_WIDTH-1:0] high_cnt;
  always_ff @(posedge in_clk)
    if (rst) begin
      high_cnt <= '0;
      high_time <= '0;
    end else begin
      high_cnt <= rise ? CNT_WIDTH'(1) : (state == MEASURE && !expire) ? high_cnt + CNT_WIDTH'(sync) : '0;
      if (load) high_time <= high_cnt;
    end
`else
  assign high_time = '0;
`endif
endmodule
